// File: rtl/nf_seven_seg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nf_seven_seg_pkg
//  Description : Shared types and constants for the multiplexed seven-segment
//                driver: segment bit positions, segment vector type and the
//                hex-to-glyph table (active-high logical form).
//  Revision    : 1.0  initial release
// ============================================================================
package nf_seven_seg_pkg;

    // Logical segment vector, bit order {dp,g,f,e,d,c,b,a}
    typedef logic [7:0] seg_t;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    localparam seg_t SEG_OFF = 8'h00;

    // Glyphs 0..F with the dp bit clear; entry 0 is the leftmost element
    localparam seg_t [0:15] c_HEX_TABLE = {
        8'h3F, 8'h06, 8'h5B, 8'h4F,
        8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C,
        8'h39, 8'h5E, 8'h79, 8'h71
    };

endpackage
`default_nettype wire

// File: rtl/nf_hex2seg.sv
`default_nettype none
// ============================================================================
//  Module      : nf_hex2seg
//  Description : Combinational nibble + decimal point to logical
//                (active-high) 8-bit segment vector.
//  Revision    : 1.0  initial release
// ============================================================================
module nf_hex2seg
    import nf_seven_seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    // Look up the glyph, then place the requested decimal point on top of it
    always_comb begin
        seg_o         = c_HEX_TABLE[nibble_i];
        seg_o[SEG_DP] = dp_i;
    end

endmodule
`default_nettype wire

// File: rtl/nf_seven_seg_scan.sv
`default_nettype none
// ============================================================================
//  Module      : nf_seven_seg_scan
//  Description : Multiplexed seven-segment scanner. Scans DIG_NUM digits one
//                slot at a time, with an all-off guard at the start of every
//                slot, per-digit blanking, decimal points, PWM brightness and
//                a frame-start snapshot of the display data so the image
//                never tears. All pins are registered.
//  Options     : NF_SEVEN_SEG_LZ_BLANK_EN - leading-zero suppression
//  Revision    : 1.0  initial release
// ============================================================================
module nf_seven_seg_scan
    import nf_seven_seg_pkg::*;
#(
    parameter int DIG_NUM   = 4,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int GUARD_CYC = 2,
    parameter int BRIGHT_W  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [4*DIG_NUM-1:0]   hex,
    input  logic [DIG_NUM-1:0]     dp,
    input  logic [DIG_NUM-1:0]     blank,
    input  logic                   cc_ca,
    input  logic [BRIGHT_W-1:0]    bright,
    output logic [7:0]             seven_seg,
    output logic [DIG_NUM-1:0]     dig,
    output logic                   frame_tick
);

    // Slot length in clocks; the configuration must keep SLOT >= GUARD_CYC+2
    localparam int c_SLOT  = CLK_FREQ / SCAN_HZ;
    localparam int c_PRE_W = (c_SLOT > 1) ? $clog2(c_SLOT) : 1;
    localparam int c_IDX_W = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST    = c_PRE_W'(c_SLOT - 1);
    localparam logic [c_IDX_W-1:0]  c_IDX_LAST    = c_IDX_W'(DIG_NUM - 1);
    localparam logic [c_PRE_W-1:0]  c_GUARD       = c_PRE_W'(GUARD_CYC);
    localparam logic [BRIGHT_W-1:0] c_BRIGHT_FULL = '1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0]        presc_q, presc_d;
    logic [c_IDX_W-1:0]        idx_q, idx_d;
    logic [BRIGHT_W-1:0]       pwm_q;
    logic                      first_q;
    logic [DIG_NUM-1:0][3:0]   hex_sh_q;
    logic [DIG_NUM-1:0]        dp_sh_q;
    logic [DIG_NUM-1:0]        blank_sh_q;
    logic [7:0]                seg_q;
    logic [DIG_NUM-1:0]        dig_q;
    logic                      frame_tick_q;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                      w_slot_end;
    logic                      w_frame_wrap;
    logic                      w_snap;
    logic                      w_in_guard;
    logic                      w_pwm_ok;
    logic [DIG_NUM-1:0]        w_lz_mask;
    logic                      w_dark;
    logic                      w_en;
    logic [7:0]                w_seg_dec;
    logic [7:0]                w_seg_log;
    logic [DIG_NUM-1:0]        w_dig_log;

    assign w_slot_end   = (presc_q == c_PRE_LAST);
    assign w_frame_wrap = w_slot_end && (idx_q == c_IDX_LAST);
    // The first cycle after reset takes a snapshot so frame 0 shows live data
    assign w_snap       = w_frame_wrap || first_q;

    // Next prescaler / digit index: slot counter wraps, index advances per slot
    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        if (w_slot_end) begin
            presc_d = '0;
            idx_d   = w_frame_wrap ? '0 : idx_q + 1'b1;
        end
    end

    // Scan counters and free-running PWM counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            pwm_q   <= '0;
            first_q <= 1'b1;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            pwm_q   <= pwm_q + 1'b1;
            first_q <= 1'b0;
        end
    end

    // Frame snapshot of the display data; held constant for a whole frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hex_sh_q   <= '0;
            dp_sh_q    <= '0;
            blank_sh_q <= '0;
        end else if (w_snap) begin
            hex_sh_q   <= hex;
            dp_sh_q    <= dp;
            blank_sh_q <= blank;
        end
    end

    // Guard window: with no guard configured the compare would be constant
    generate
        if (GUARD_CYC == 0) begin : g_no_guard
            assign w_in_guard = 1'b0;
        end else begin : g_guard
            assign w_in_guard = (presc_q < c_GUARD);
        end
    endgenerate

    assign w_pwm_ok = (pwm_q < bright) || (bright == c_BRIGHT_FULL);

`ifdef NF_SEVEN_SEG_LZ_BLANK_EN
    // Leading-zero mask: walk down from the top digit until a non-zero
    // nibble or a lit decimal point; digit 0 is always shown
    always_comb begin
        logic v_run;
        w_lz_mask = '0;
        v_run     = 1'b1;
        for (int i = DIG_NUM - 1; i >= 1; i--) begin
            if (v_run && (hex_sh_q[i] == 4'h0) && !dp_sh_q[i]) begin
                w_lz_mask[i] = 1'b1;
            end else begin
                v_run = 1'b0;
            end
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    assign w_dark = blank_sh_q[idx_q] || w_lz_mask[idx_q];
    assign w_en   = !w_in_guard && !w_dark && w_pwm_ok;

    nf_hex2seg u_hex2seg (
        .nibble_i (hex_sh_q[idx_q]),
        .dp_i     (dp_sh_q[idx_q]),
        .seg_o    (w_seg_dec)
    );

    // Logical (active-high) pin image for the current counter state
    always_comb begin
        w_dig_log = '0;
        w_seg_log = SEG_OFF;
        if (w_en) begin
            w_dig_log[idx_q] = 1'b1;
            w_seg_log        = w_seg_dec;
        end
    end

    // Output registers with polarity applied; reset drives a dark CC image
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q        <= SEG_OFF;
            dig_q        <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= cc_ca ? ~w_seg_log : w_seg_log;
            dig_q        <= cc_ca ? w_dig_log  : ~w_dig_log;
            frame_tick_q <= w_frame_wrap;
        end
    end

    assign seven_seg  = seg_q;
    assign dig        = dig_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
